// File: rtl/alu_seq.sv
// Registered SAP-II style ALU: twelve single-cycle ops plus multi-cycle multiply and rotates.
// A start/busy/done handshake frames each operation, and a tri-state port drives the W-bus.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] t,
    input  logic             out_en,
    output logic [WIDTH-1:0] out_bus,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned Msb  = WIDTH - 1;
    localparam logic [WIDTH:0] OneW = 1;

    localparam logic [3:0] OpMul  = 4'hC;
    localparam logic [3:0] OpRoln = 4'hD;
    localparam logic [3:0] OpCmp  = 4'hE;
    localparam logic [3:0] OpRorn = 4'hF;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mpl_q, mpl_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_z, alu_s, alu_v;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo, rot_x;
    logic [CW-1:0]    n_in;

    assign n_in = t[CW-1:0];

    // Single-cycle datapath, evaluated on the live operands during the start edge.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            4'h0: alu_r = a & t;
            4'h1: alu_r = a | t;
            4'h2: alu_r = a ^ t;
            4'h3: begin
                {alu_c, alu_r} = {1'b0, a} + {1'b0, t};
                alu_v = (a[Msb] == t[Msb]) && (alu_r[Msb] != a[Msb]);
            end
            4'h4: begin
                {alu_c, alu_r} = {1'b0, a} - {1'b0, t};
                alu_v = (a[Msb] != t[Msb]) && (alu_r[Msb] != a[Msb]);
            end
            4'h5: alu_r = ~a;
            4'h6: begin
                {alu_c, alu_r} = {1'b0, a} + OneW;
                alu_v = ~a[Msb] & alu_r[Msb];
            end
            4'h7: begin
                {alu_c, alu_r} = {1'b0, a} - OneW;
                alu_v = a[Msb] & ~alu_r[Msb];
            end
            4'h8: alu_r = {a[Msb-1:0], a[Msb]};
            4'h9: alu_r = {a[0], a[Msb:1]};
            4'hA: begin
                {alu_c, alu_r} = {1'b0, t} + OneW;
                alu_v = ~t[Msb] & alu_r[Msb];
            end
            4'hB: begin
                {alu_c, alu_r} = {1'b0, t} - OneW;
                alu_v = t[Msb] & ~alu_r[Msb];
            end
            4'hD, 4'hF: alu_r = a;
            4'hE: begin
                alu_r = result_q;
                alu_c = a < t;
            end
            default: alu_r = '0;
        endcase
        alu_z = (op == OpCmp) ? (a == t) : (alu_r == '0);
        alu_s = (op == OpCmp) ? ($signed(a) < $signed(t)) : alu_r[Msb];
    end

    // One shift-add step per RUN cycle; the multiplier shifts out as product bits shift in.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, x_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], mpl_q[WIDTH-1:1]};
        rot_x   = (op_q == OpRoln) ? {x_q[Msb-1:0], x_q[Msb]} : {x_q[0], x_q[Msb:1]};
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        acc_d       = acc_q;
        mpl_d       = mpl_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d  = op;
                    x_d   = a;
                    mpl_d = t;
                    acc_d = '0;
                    if (op == OpMul) begin
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = StRun;
                    end else if ((op == OpRoln || op == OpRorn) && n_in != '0) begin
                        cnt_d   = n_in - CW'(1);
                        state_d = StRun;
                    end else begin
                        result_d    = alu_r;
                        result_hi_d = '0;
                        carry_d     = alu_c;
                        zero_d      = alu_z;
                        sign_d      = alu_s;
                        ovf_d       = alu_v;
                        state_d     = StFin;
                    end
                end
            end
            StRun: begin
                if (op_q == OpMul) begin
                    acc_d = mul_hi;
                    mpl_d = mul_lo;
                end else begin
                    x_d = rot_x;
                end
                if (cnt_q == '0) begin
                    state_d = StFin;
                    ovf_d   = 1'b0;
                    if (op_q == OpMul) begin
                        result_d    = mul_lo;
                        result_hi_d = mul_hi;
                        carry_d     = |mul_hi;
                        zero_d      = (mul_lo == '0);
                        sign_d      = mul_lo[Msb];
                    end else begin
                        result_d    = rot_x;
                        result_hi_d = '0;
                        carry_d     = 1'b0;
                        zero_d      = (rot_x == '0);
                        sign_d      = rot_x[Msb];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            mpl_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            mpl_q       <= mpl_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StFin);
    assign out_bus   = out_en ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: expectations come from a behavioural model,
// are queued at stimulus time and retired on each done pulse.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] a, t;
    logic       out_en;
    logic [7:0] out_bus, result, result_hi;
    logic       carry, zero, sign, ovf, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       s;
        logic       v;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] prev_r;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .t         (t),
        .out_en    (out_en),
        .out_bus   (out_bus),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .sign      (sign),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x,
                                   input logic [7:0] y, input logic [7:0] prev);
        exp_t e;
        int   sx, sy, n, res;
        logic [15:0] p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        n  = int'(y[2:0]);
        e  = '0;
        case (o)
            4'h0: e.r = x & y;
            4'h1: e.r = x | y;
            4'h2: e.r = x ^ y;
            4'h3: begin
                res = int'(x) + int'(y);
                e.r = res[7:0]; e.c = (res > 255); e.v = (sx + sy > 127) || (sx + sy < -128);
            end
            4'h4: begin
                e.r = x - y; e.c = (x < y); e.v = (sx - sy > 127) || (sx - sy < -128);
            end
            4'h5: e.r = ~x;
            4'h6: begin e.r = x + 8'd1; e.c = (x == 8'hFF); e.v = (x == 8'h7F); end
            4'h7: begin e.r = x - 8'd1; e.c = (x == 8'h00); e.v = (x == 8'h80); end
            4'h8: e.r = (x << 1) | (x >> 7);
            4'h9: e.r = (x >> 1) | (x << 7);
            4'hA: begin e.r = y + 8'd1; e.c = (y == 8'hFF); e.v = (y == 8'h7F); end
            4'hB: begin e.r = y - 8'd1; e.c = (y == 8'h00); e.v = (y == 8'h80); end
            4'hC: begin
                p = 16'(x) * 16'(y);
                e.r = p[7:0]; e.hi = p[15:8]; e.c = (p[15:8] != 8'h00);
            end
            4'hD: begin res = (int'(x) << n) | (int'(x) >> (8 - n)); e.r = res[7:0]; end
            4'hF: begin res = (int'(x) >> n) | (int'(x) << (8 - n)); e.r = res[7:0]; end
            default: e.r = prev;
        endcase
        if (o == 4'hE) begin
            e.c = (x < y); e.z = (x == y); e.s = (sx < sy);
        end else begin
            e.z = (e.r == 8'h00); e.s = e.r[7];
        end
        return e;
    endfunction

    task automatic retire();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("result", 32'(result), 32'(e.r));
            check_eq("result_hi", 32'(result_hi), 32'(e.hi));
            check_eq("carry", 32'(carry), 32'(e.c));
            check_eq("zero", 32'(zero), 32'(e.z));
            check_eq("sign", 32'(sign), 32'(e.s));
            check_eq("ovf", 32'(ovf), 32'(e.v));
            check_eq("out_bus", 32'(out_bus), 32'(e.r));
        end
    endtask

    // poke pulses start during the operation; it must not spawn a second done.
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input bit poke);
        exp_t e;
        int   lat, exp_lat, busy_n, extra;
        bit   seen;
        @(negedge clk);
        e = model(o, x, y, prev_r);
        prev_r = e.r;
        sb_q.push_back(e);
        if (o == 4'hC) exp_lat = 9;
        else if ((o == 4'hD || o == 4'hF) && y[2:0] != 3'd0) exp_lat = int'(y[2:0]) + 1;
        else exp_lat = 1;
        start = 1'b1; op = o; a = x; t = y;
        seen = 1'b0; lat = 0; busy_n = 0; extra = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (poke && i == 3) start = 1'b1;
            if (poke && i == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                retire();
            end
        end
        start = 1'b0;
        if (!seen) check_eq("timeout", 32'd0, 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_cycles", 32'(busy_n), 32'(exp_lat));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_eq("extra_done", 32'(extra), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; op = 4'hC; a = 8'hFF; t = 8'hFF; out_en = 1'b0;
        prev_r = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_done", 32'(done), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_outs", {8'(result), 8'(result_hi), 4'(0),
                                  carry, zero, sign, ovf, 8'd0}, 32'd0);
        end
        out_en = 1'b1;
        #1 check_eq("rst_out_bus", 32'(out_bus), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("post_rst_done", 32'(done), 32'd0);

        run_op(4'h3, 8'hF0, 8'h20, 1'b0);
        run_op(4'h3, 8'h7F, 8'h01, 1'b0);
        run_op(4'h4, 8'h00, 8'h01, 1'b0);
        run_op(4'h6, 8'hFF, 8'h00, 1'b0);
        run_op(4'hC, 8'hFF, 8'hFF, 1'b1);
        run_op(4'hD, 8'h81, 8'h03, 1'b0);
        run_op(4'hF, 8'h81, 8'h00, 1'b0);
        run_op(4'h3, 8'hF0, 8'h20, 1'b0);
        run_op(4'hE, 8'h05, 8'h05, 1'b0);
        run_op(4'hE, 8'h80, 8'h01, 1'b0);
        run_op(4'h0, 8'hCA, 8'h0F, 1'b0);
        run_op(4'h1, 8'hCA, 8'h05, 1'b0);
        run_op(4'h2, 8'hAA, 8'hFF, 1'b0);
        run_op(4'h5, 8'h00, 8'h00, 1'b0);
        run_op(4'h7, 8'h00, 8'h00, 1'b0);
        run_op(4'h7, 8'h80, 8'h00, 1'b0);
        run_op(4'h4, 8'h80, 8'h01, 1'b0);
        run_op(4'h8, 8'h81, 8'h00, 1'b0);
        run_op(4'h9, 8'h81, 8'h00, 1'b0);
        run_op(4'hA, 8'h00, 8'h7F, 1'b0);
        run_op(4'hB, 8'h00, 8'h00, 1'b0);
        run_op(4'hC, 8'h0D, 8'h0B, 1'b0);
        run_op(4'hC, 8'h00, 8'h37, 1'b0);
        run_op(4'hF, 8'h81, 8'h03, 1'b0);
        run_op(4'hD, 8'h96, 8'h07, 1'b0);

        // Abort a multiply part-way through RUN.
        @(negedge clk);
        start = 1'b1; op = 4'hC; a = 8'hFF; t = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_outs", {8'(result), 8'(result_hi), 4'(0),
                                carry, zero, sign, ovf, 8'd0}, 32'd0);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check_eq("abort_no_done", 32'(extra), 32'd0);
        end
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the SAP-II combinational ALU.
- Performs the same 12 single-cycle operations on WIDTH-bit operands A (accumulator) and T (temp register).
- Adds registered status flags, a start/busy/done handshake, multi-cycle shift-add multiply, multi-bit rotates and compare.
- Sits between the A/T registers and the shared tri-state W-bus, driving the bus only when out_en is high.

Parameters:
- WIDTH, 8, operand/result width in bits; ≥ 4.
- CW, $clog2(WIDTH), width of rotate-count field and internal cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation select; latched with start.
- a  in  WIDTH  accumulator operand; latched with start.
- t  in  WIDTH  temp operand; latched with start.
- out_en  in  1  bus drive enable (combinational, independent of state).
- out_bus  out  WIDTH  result when out_en=1, else high-Z.
- result  out  WIDTH  registered result (low half for MUL).
- result_hi  out  WIDTH  high half of MUL product; 0 after any non-MUL op.
- carry  out  1  carry/borrow flag.
- zero  out  1  result == 0.
- sign  out  1  result MSB.
- ovf  out  1  signed overflow.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high rst): all outputs 0, FSM→IDLE, counter 0. out_bus is Z unless out_en=1, in which case it drives 0. Reset mid-operation aborts the operation; no done pulse is issued.
- FSM states: IDLE, RUN, FIN. IDLE+start → latch op/a/t; single-cycle ops → FIN; MUL, ROLN, RORN with count>0 → RUN. RUN → FIN when the counter expires. FIN → IDLE unconditionally.
- done=1 exactly in FIN. busy=1 in RUN and FIN. Result and flags are written on the edge entering FIN and hold until the next op completes.
- start in RUN/FIN is ignored (not queued). start held high re-triggers in IDLE.
- Latency: single-cycle op completes in 2 cycles from the start edge (done high the cycle after the edge). MUL: WIDTH RUN cycles. ROLN/RORN: count RUN cycles.
- Opcodes (x = latched a, y = latched t, n = y[CW-1:0]):
  - 0 AND; 1 OR; 2 XOR.
  - 3 ADD: {carry,r}=x+y.
  - 4 SUB: {carry,r}=x−y; carry=borrow.
  - 5 NOT x.
  - 6 INC x: carry=carry-out.
  - 7 DEC x: carry=borrow.
  - 8 ROL1; 9 ROR1; A INC y; B DEC y.
  - C MUL: unsigned shift-add, one partial product per RUN cycle; {result_hi,result}=x*y; carry = |result_hi.
  - D ROLN: rotate x left n places, one bit per RUN cycle.
  - E CMP: result unchanged; carry = (x<y unsigned); zero = (x==y); sign = (x<y signed); ovf=0.
  - F RORN: rotate x right n places, one bit per RUN cycle.
- Flags:
  - zero and sign follow the new result (except CMP).
  - carry is written only by ops 3, 4, 6, 7, A, B, C, E; all other ops clear it. There is no hold/latch behaviour.
  - ovf = signed overflow for ADD/SUB/INC/DEC/INC y/DEC y; 0 for all other ops.
- Wrap-around: INC of all-ones → 0, carry=1, zero=1. DEC of 0 → all-ones, carry=1, sign=1.
- ROLN/RORN with n=0 complete as single-cycle ops, result=x. n is taken modulo WIDTH by construction.

Test Plan:
- rst high 2 cycles with start=1 → all outputs 0, busy=0, done never pulses. out_en=0 → out_bus=Z; out_en=1 → out_bus=0.
- WIDTH=8, op=3, a=0xF0, t=0x20 → done one cycle after the start edge; result=0x10, carry=1, zero=0, ovf=0. Then op=3, a=0x7F, t=0x01 → result=0x80, sign=1, ovf=1, carry=0.
- op=4, a=0x00, t=0x01 → result=0xFF, carry=1 (borrow), sign=1. Then op=6, a=0xFF → result=0x00, zero=1, carry=1.
- op=C, a=0xFF, t=0xFF → busy for 9 cycles, done after 8 RUN cycles; {result_hi,result}=0xFE01, carry=1. A start pulse mid-RUN is ignored, so only one done is seen.
- op=D, a=0x81, t=0x03 → 3 RUN cycles, result=0x0C. op=F, a=0x81, t=0x00 → single-cycle, result=0x81.
- op=E, a=0x05, t=0x05 after a prior ADD result 0x10 → result stays 0x10; zero=1, carry=0. Separately, assert rst during MUL RUN → next cycle IDLE, outputs 0, no done.
